// File: rtl/tomasulo_pkg.sv
// Shared constants and state encoding for the architectural-state dump path.
package tomasulo_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      DUMP_IDLE,
      DUMP_READ,
      DUMP_SEND,
      DUMP_FINISH
   } dump_state_t;

endpackage

// File: rtl/reg_dump_streamer.sv
// Walks the register file once per core_done rising edge and streams {addr, data}
// beats over valid/ready, keeping a wrapping sum of every accepted beat.
module reg_dump_streamer
   import tomasulo_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = REG_ADDR_W,
   parameter int unsigned DATA_W   = XLEN,
   parameter bit          SKIP_X0  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_done,
   output logic [ADDR_W-1:0] reg_addr,
   input  logic [DATA_W-1:0] reg_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              dump_busy,
   output logic              dump_done,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [ADDR_W-1:0] FirstIdx = SKIP_X0 ? ADDR_W'(1) : '0;
   localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);

   dump_state_t       state_q, state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [DATA_W-1:0] out_data_q;
   logic [DATA_W-1:0] checksum_q;
   logic              done_q;
   logic              start;
   logic              beat_fire;
   logic              last_beat;

   assign start     = core_done & ~done_q;
   assign beat_fire = (state_q == DUMP_SEND) & out_ready;
   assign last_beat = (idx_q == LastIdx);

   // idx only moves on start and on an accepted beat, so it doubles as the
   // read address: it shows idx in READ and holds its last value elsewhere.
   assign reg_addr = idx_q;
   assign out_addr = out_addr_q;
   assign out_data = out_data_q;
   assign checksum = checksum_q;

   // Sampled through reset too, so a level held high across reset is not an edge.
   always_ff @(posedge clk) begin
      done_q <= core_done;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DUMP_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DUMP_IDLE:   if (start) state_d = DUMP_READ;
         DUMP_READ:   state_d = DUMP_SEND;
         DUMP_SEND:   if (beat_fire) state_d = last_beat ? DUMP_FINISH : DUMP_READ;
         DUMP_FINISH: if (!core_done) state_d = DUMP_IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      dump_busy = 1'b0;
      dump_done = 1'b0;
      unique case (state_q)
         DUMP_IDLE:   ;
         DUMP_READ:   dump_busy = 1'b1;
         DUMP_SEND: begin
            dump_busy = 1'b1;
            out_valid = 1'b1;
         end
         DUMP_FINISH: dump_done = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q      <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         checksum_q <= '0;
      end else begin
         unique case (state_q)
            DUMP_IDLE: begin
               if (start) begin
                  idx_q      <= FirstIdx;
                  checksum_q <= '0;
               end
            end
            DUMP_READ: begin
               out_addr_q <= idx_q;
               out_data_q <= reg_data;
            end
            DUMP_SEND: begin
               if (beat_fire) begin
                  checksum_q <= checksum_q + out_data_q;
                  if (!last_beat) idx_q <= idx_q + ADDR_W'(1);
               end
            end
            DUMP_FINISH: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Bench for reg_dump_streamer: directed scenarios plus randomized data and sink
// backpressure, checked against an expected beat list and arithmetic checksum.
module tb_reg_dump_streamer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] regs [32];

   logic        m_core_done, m_out_valid, m_out_ready, m_busy, m_done;
   logic [4:0]  m_reg_addr, m_out_addr;
   logic [31:0] m_reg_data, m_out_data, m_checksum;

   logic        s_core_done, s_out_valid, s_out_ready, s_busy, s_done;
   logic [4:0]  s_reg_addr, s_out_addr;
   logic [31:0] s_reg_data, s_out_data, s_checksum;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign m_reg_data = regs[m_reg_addr];
   assign s_reg_data = regs[s_reg_addr];

   reg_dump_streamer #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b0)) dut (
      .clk(clk), .reset(reset), .core_done(m_core_done), .reg_addr(m_reg_addr),
      .reg_data(m_reg_data), .out_valid(m_out_valid), .out_ready(m_out_ready),
      .out_addr(m_out_addr), .out_data(m_out_data), .dump_busy(m_busy),
      .dump_done(m_done), .checksum(m_checksum)
   );

   reg_dump_streamer #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_X0(1'b1)) dut_skip (
      .clk(clk), .reset(reset), .core_done(s_core_done), .reg_addr(s_reg_addr),
      .reg_data(s_reg_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_addr(s_out_addr), .out_data(s_out_data), .dump_busy(s_busy),
      .dump_done(s_done), .checksum(s_checksum)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_done(input bit skip, input logic val);
      if (skip) s_core_done = val;
      else m_core_done = val;
   endtask

   task automatic set_ready(input bit skip, input logic val);
      if (skip) s_out_ready = val;
      else m_out_ready = val;
   endtask

   // mode 0: sink always ready; 1: random ready; 2: ready held low 5 cycles on beat 3.
   task automatic run_dump(input bit skip, input int mode, input bit drop_mid);
      logic [4:0]  exp_addr [$];
      logic [31:0] exp_sum;
      int          nbeats, got, cyc, hold;
      logic        v, rdy, dn, bsy, stall;
      logic [4:0]  a, pa, first;
      logic [31:0] d, pd, cs;
      exp_sum = '0;
      first   = skip ? 5'd1 : 5'd0;
      for (int i = int'(first); i < 32; i++) begin
         exp_addr.push_back(5'(i));
         exp_sum += regs[i];
      end
      nbeats = exp_addr.size();
      got    = 0;
      hold   = 0;
      stall  = 1'b0;
      dn     = 1'b0;
      pa     = '0;
      pd     = '0;
      set_ready(skip, 1'b0);
      set_done(skip, 1'b0);
      step();
      set_done(skip, 1'b1);
      for (cyc = 1; cyc <= 400; cyc++) begin
         step();
         v   = skip ? s_out_valid : m_out_valid;
         a   = skip ? s_out_addr  : m_out_addr;
         d   = skip ? s_out_data  : m_out_data;
         dn  = skip ? s_done      : m_done;
         bsy = skip ? s_busy      : m_busy;
         if (cyc == 1) begin
            chk("busy_after_start", 32'(bsy), 32'd1);
            chk("valid_latency_c1", 32'(v), 32'd0);
         end
         if (cyc == 2) begin
            chk("valid_latency_c2", 32'(v), 32'd1);
            chk("first_addr", 32'(a), 32'(first));
         end
         if (drop_mid && cyc == 10) set_done(skip, 1'b0);
         if (dn) break;
         if (stall) begin
            chk("stall_valid", 32'(v), 32'd1);
            chk("stall_addr", 32'(a), 32'(pa));
            chk("stall_data", d, pd);
         end
         rdy = 1'b1;
         if (mode == 1) rdy = 1'($urandom_range(0, 1));
         if (mode == 2 && v && a == 5'd3 && hold < 5) begin
            rdy = 1'b0;
            hold++;
         end
         set_ready(skip, rdy);
         if (v && rdy) begin
            got++;
            if (exp_addr.size() != 0) begin
               chk("beat_addr", 32'(a), 32'(exp_addr[0]));
               chk("beat_data", d, regs[exp_addr[0]]);
               void'(exp_addr.pop_front());
            end
         end
         stall = v && !rdy;
         pa    = a;
         pd    = d;
      end
      set_ready(skip, 1'b0);
      v   = skip ? s_out_valid : m_out_valid;
      bsy = skip ? s_busy      : m_busy;
      cs  = skip ? s_checksum  : m_checksum;
      chk("dump_done_reached", 32'(dn), 32'd1);
      chk("beat_count", 32'(got), 32'(nbeats));
      chk("checksum", cs, exp_sum);
      chk("finish_busy", 32'(bsy), 32'd0);
      chk("finish_valid", 32'(v), 32'd0);
      if (mode == 0) chk("dump_cycles", 32'(cyc), 32'(2 * nbeats + 1));
      if (mode == 2) chk("stall_cycles", 32'(hold), 32'd5);
      if (!drop_mid) begin
         repeat (3) step();
         chk("no_retrigger_done", 32'(skip ? s_done : m_done), 32'd1);
         chk("no_retrigger_busy", 32'(skip ? s_busy : m_busy), 32'd0);
         set_done(skip, 1'b0);
         step();
      end
      step();
      chk("back_to_idle", 32'(skip ? s_done : m_done), 32'd0);
   endtask

   initial begin
      logic [31:0] part_sum;
      int          beats;
      reset       = 1'b1;
      m_core_done = 1'b1;
      s_core_done = 1'b0;
      m_out_ready = 1'b0;
      s_out_ready = 1'b0;
      for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11;

      // Reset held with core_done high.
      repeat (3) step();
      chk("rst_valid", 32'(m_out_valid), 32'd0);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_done", 32'(m_done), 32'd0);
      chk("rst_checksum", m_checksum, 32'd0);
      chk("rst_out_addr", 32'(m_out_addr), 32'd0);
      chk("rst_out_data", m_out_data, 32'd0);
      chk("rst_reg_addr", 32'(m_reg_addr), 32'd0);
      reset = 1'b0;
      repeat (4) step();
      chk("no_dump_after_rst_busy", 32'(m_busy), 32'd0);
      chk("no_dump_after_rst_valid", 32'(m_out_valid), 32'd0);

      run_dump(1'b0, 0, 1'b0);
      chk("full_dump_checksum", m_checksum, 32'h0000_20F0);

      run_dump(1'b0, 2, 1'b0);

      for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
      run_dump(1'b0, 0, 1'b0);
      chk("wrap_checksum", m_checksum, 32'hFFFF_FFE0);

      for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11;
      run_dump(1'b1, 0, 1'b0);
      chk("skip_checksum", s_checksum, 32'h0000_20F0);

      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 32; i++) regs[i] = $urandom;
         run_dump(1'b0, 1, 1'(t % 2));
      end

      // Reset after beat 10 has been accepted.
      part_sum = '0;
      for (int i = 0; i <= 10; i++) part_sum += regs[i];
      beats = 0;
      m_core_done = 1'b0;
      m_out_ready = 1'b1;
      step();
      m_core_done = 1'b1;
      for (int c = 0; c < 100 && beats < 11; c++) begin
         step();
         if (m_out_valid) beats++;
      end
      step();
      chk("mid_beats", 32'(beats), 32'd11);
      chk("mid_partial_checksum", m_checksum, part_sum);
      reset = 1'b1;
      step();
      chk("mid_rst_valid", 32'(m_out_valid), 32'd0);
      chk("mid_rst_busy", 32'(m_busy), 32'd0);
      chk("mid_rst_checksum", m_checksum, 32'd0);
      chk("mid_rst_done", 32'(m_done), 32'd0);
      reset = 1'b0;
      m_out_ready = 1'b0;
      repeat (2) step();
      chk("mid_rst_no_restart", 32'(m_busy), 32'd0);
      run_dump(1'b0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
